// File: rtl/mio_ctrl.sv
// mio_ctrl: load/store sequencer between the single-cycle MIPS core and the MIO bus.
// Optional stall statistics counter is built only when MIO_CTRL_STATS_EN is defined.
//
// state | meaning
// IDLE  | core runs at full speed; a load/store latches the bus request
// BUSY  | bus request outstanding, core stalled, wait counter running
// DONE  | single commit cycle for the stalled instruction
module mio_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        pc_en,
  output logic [31:0] cpu_rdata,
  output logic        CPU_MIO,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        MIO_ready,
  output logic        timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_bus_we;
  logic        r_timeout;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_cpu_rdata;
  logic [15:0] r_wait;
  logic        w_start;
  logic        w_ready;
  logic        w_expire;

  assign w_start  = (r_state == S_IDLE) && cpu_req;
  assign w_ready  = (r_state == S_BUSY) && MIO_ready;
  // ready on the last count takes priority over the timeout
  assign w_expire = (r_state == S_BUSY) && !MIO_ready && (r_wait == LP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req) w_next = S_BUSY;
      S_BUSY:  if (w_ready || w_expire) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en   = 1'b0;
    CPU_MIO = 1'b0;
    bus_we  = 1'b0;
    case (r_state)
      S_IDLE:  pc_en = ~cpu_req;
      S_BUSY: begin
        CPU_MIO = 1'b1;
        bus_we  = r_bus_we;
      end
      S_DONE:  pc_en = 1'b1;
      default: pc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_cpu_rdata <= '0;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_start) begin
        r_bus_we    <= cpu_we;
        r_bus_addr  <= cpu_addr;
        r_bus_wdata <= cpu_wdata;
        r_wait      <= '0;
      end else if ((r_state == S_BUSY) && !MIO_ready && !w_expire) begin
        r_wait <= r_wait + 16'd1;
      end
      if (w_ready && !r_bus_we) begin
        r_cpu_rdata <= bus_rdata;
      end else if (w_expire) begin
        r_timeout <= 1'b1;
        if (!r_bus_we) r_cpu_rdata <= '0;
      end
    end
  end

  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign timeout   = r_timeout;

`ifdef MIO_CTRL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_stall_cnt <= '0;
    else if (!pc_en && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mio_ctrl.sv
// Directed self-checking bench for mio_ctrl: default-timeout instance plus a
// TIMEOUT_CYCLES=4 instance; a long-timeout instance exercises stall saturation.
module tb_mio_ctrl;

`ifdef MIO_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, MIO_ready;
  logic [31:0] cpu_addr, cpu_wdata, bus_rdata;
  logic        pc_en, CPU_MIO, bus_we, timeout;
  logic [31:0] cpu_rdata, bus_addr, bus_wdata;
  logic [15:0] stall_cnt;

  logic        t_req, t_ready;
  logic        t_pc_en, t_CPU_MIO, t_bus_we, t_timeout;
  logic [31:0] t_cpu_rdata, t_bus_addr, t_bus_wdata;
  logic [15:0] t_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mio_ctrl u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .pc_en(pc_en),
    .cpu_rdata(cpu_rdata), .CPU_MIO(CPU_MIO), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .MIO_ready(MIO_ready), .timeout(timeout), .stall_cnt(stall_cnt)
  );

  mio_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .reset(reset), .cpu_req(t_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .pc_en(t_pc_en),
    .cpu_rdata(t_cpu_rdata), .CPU_MIO(t_CPU_MIO), .bus_we(t_bus_we),
    .bus_addr(t_bus_addr), .bus_wdata(t_bus_wdata), .bus_rdata(bus_rdata),
    .MIO_ready(t_ready), .timeout(t_timeout), .stall_cnt(t_stall_cnt)
  );

`ifdef MIO_CTRL_STATS_EN
  logic        s_req;
  logic        s_ready = 1'b0;
  logic        s_pc_en, s_CPU_MIO, s_bus_we, s_timeout;
  logic [31:0] s_cpu_rdata, s_bus_addr, s_bus_wdata;
  logic [15:0] s_stall_cnt;

  mio_ctrl #(.TIMEOUT_CYCLES(40000)) u_dut_sat (
    .clk(clk), .reset(reset), .cpu_req(s_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .pc_en(s_pc_en),
    .cpu_rdata(s_cpu_rdata), .CPU_MIO(s_CPU_MIO), .bus_we(s_bus_we),
    .bus_addr(s_bus_addr), .bus_wdata(s_bus_wdata), .bus_rdata(bus_rdata),
    .MIO_ready(s_ready), .timeout(s_timeout), .stall_cnt(s_stall_cnt)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; MIO_ready = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; bus_rdata = '0;
    t_req = 1'b0; t_ready = 1'b0;
`ifdef MIO_CTRL_STATS_EN
    s_req = 1'b0;
`endif

    // reset with no request: pass-through values every cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_pc_en", pc_en, 1);
      chk("rst_cpu_mio", CPU_MIO, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_stall", stall_cnt, 0);
    end

    // zero-wait load
    next_cyc();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hE000_0000;
    @(negedge clk);
    chk("ld_N_pc_en", pc_en, 0);
    chk("ld_N_cpu_mio", CPU_MIO, 0);
    next_cyc();
    MIO_ready = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("ld_N1_cpu_mio", CPU_MIO, 1);
    chk("ld_N1_pc_en", pc_en, 0);
    chk("ld_N1_bus_addr", bus_addr, 32'hE000_0000);
    chk("ld_N1_bus_we", bus_we, 0);
    next_cyc();
    MIO_ready = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ld_N2_pc_en", pc_en, 1);
    chk("ld_N2_cpu_mio", CPU_MIO, 0);
    chk("ld_N2_rdata", cpu_rdata, 32'h1234_5678);
    chk("ld_N2_stall", stall_cnt, STATS ? 2 : 0);

    // back-to-back wait-state store
    next_cyc();
    cpu_we = 1'b1; cpu_addr = 32'h1000_0004; cpu_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("st_N_pc_en", pc_en, 0);
    chk("st_N_cpu_mio", CPU_MIO, 0);
    for (int k = 1; k <= 5; k++) begin
      next_cyc();
      MIO_ready = (k == 5);
      bus_rdata = 32'h5555_0000 | k;
      cpu_wdata = 32'h0000_0000;
      cpu_addr  = 32'h0000_0000;
      @(negedge clk);
      chk("st_busy_cpu_mio", CPU_MIO, 1);
      chk("st_busy_bus_we", bus_we, 1);
      chk("st_busy_wdata", bus_wdata, 32'hA5A5_A5A5);
      chk("st_busy_addr", bus_addr, 32'h1000_0004);
      chk("st_busy_pc_en", pc_en, 0);
    end
    next_cyc();
    MIO_ready = 1'b0;
    @(negedge clk);
    chk("st_N6_pc_en", pc_en, 1);
    chk("st_N6_cpu_mio", CPU_MIO, 0);
    chk("st_N6_bus_we", bus_we, 0);
    chk("st_N6_rdata", cpu_rdata, 32'h1234_5678);
    chk("st_N6_stall", stall_cnt, STATS ? 8 : 0);
    next_cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("idle_pc_en", pc_en, 1);
    chk("idle_cpu_mio", CPU_MIO, 0);

    // TIMEOUT_CYCLES=4: ready on the last count wins over the timeout
    next_cyc();
    t_req = 1'b1; cpu_addr = 32'h2000_0000; bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("tb_N_pc_en", t_pc_en, 0);
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      t_ready = (k == 4);
      @(negedge clk);
      chk("tb_busy_cpu_mio", t_CPU_MIO, 1);
      chk("tb_busy_pc_en", t_pc_en, 0);
    end
    next_cyc();
    t_ready = 1'b0;
    @(negedge clk);
    chk("tb_done_pc_en", t_pc_en, 1);
    chk("tb_done_rdata", t_cpu_rdata, 32'h0BAD_F00D);
    chk("tb_done_timeout", t_timeout, 0);

    // TIMEOUT_CYCLES=4: no ready, abandoned after 4 BUSY cycles
    next_cyc();
    cpu_addr = 32'h2000_0008;
    @(negedge clk);
    chk("to_N_pc_en", t_pc_en, 0);
    chk("to_N_cpu_mio", t_CPU_MIO, 0);
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      @(negedge clk);
      chk("to_busy_cpu_mio", t_CPU_MIO, 1);
      chk("to_busy_timeout", t_timeout, 0);
    end
    next_cyc();
    @(negedge clk);
    chk("to_done_pc_en", t_pc_en, 1);
    chk("to_done_cpu_mio", t_CPU_MIO, 0);
    chk("to_done_rdata", t_cpu_rdata, 0);
    chk("to_done_timeout", t_timeout, 1);
    t_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      @(negedge clk);
      chk("to_sticky", t_timeout, 1);
      chk("to_after_pc_en", t_pc_en, 1);
    end

    // reset in the middle of a waiting store
    next_cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h3000_0000; cpu_wdata = 32'h1111_2222;
    @(negedge clk);
    chk("rm_N_pc_en", pc_en, 0);
    next_cyc();
    @(negedge clk);
    chk("rm_N1_cpu_mio", CPU_MIO, 1);
    next_cyc();
    @(negedge clk);
    chk("rm_N2_cpu_mio", CPU_MIO, 1);
    chk("rm_N2_bus_we", bus_we, 1);
    reset = 1'b1;
    #1;
    chk("rm_async_cpu_mio", CPU_MIO, 0);
    chk("rm_async_bus_we", bus_we, 0);
    chk("rm_async_timeout", t_timeout, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rm_rel_pc_en", pc_en, 1);
    chk("rm_rel_cpu_mio", CPU_MIO, 0);
    chk("rm_rel_bus_addr", bus_addr, 0);
    chk("rm_rel_stall", stall_cnt, 0);
    next_cyc();
    @(negedge clk);
    chk("rm_idle_pc_en", pc_en, 1);

`ifdef MIO_CTRL_STATS_EN
    // two 40000-cycle timeouts give more than 65535 stall cycles
    next_cyc();
    s_req = 1'b1;
    repeat (82000) @(posedge clk);
    #1;
    s_req = 1'b0;
    repeat (3) next_cyc();
    @(negedge clk);
    chk("sat_stall", s_stall_cnt, 32'h0000_FFFF);
    chk("sat_timeout", s_timeout, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
